// File: rtl/piano_pkg.sv
// Shared piano constants: key count, record layout, recorder FSM states and note indices.
package piano_pkg;

   localparam int unsigned NUM_KEYS  = 24;
   localparam int unsigned NOTE_W    = 5;
   localparam int unsigned TIME_W    = 29;
   localparam int unsigned REC_W     = NOTE_W + 2 * TIME_W;

   // Packed record layout: {note, start, end}
   localparam int unsigned NOTE_LSB  = 58;
   localparam int unsigned START_LSB = 29;
   localparam int unsigned END_LSB   = 0;

   typedef enum logic [1:0] {IDLE, REC, FLUSH} rec_state_e;

   // Key index to note name, as used by the tone generator
   localparam logic [NOTE_W-1:0] KEY_C4  = 5'd0,  KEY_D4  = 5'd1,  KEY_E4  = 5'd2;
   localparam logic [NOTE_W-1:0] KEY_F4  = 5'd3,  KEY_G4  = 5'd4,  KEY_A4  = 5'd5;
   localparam logic [NOTE_W-1:0] KEY_B4  = 5'd6,  KEY_C5  = 5'd7,  KEY_D5  = 5'd8;
   localparam logic [NOTE_W-1:0] KEY_E5  = 5'd9,  KEY_F5  = 5'd10, KEY_G5  = 5'd11;
   localparam logic [NOTE_W-1:0] KEY_A5  = 5'd12, KEY_B5  = 5'd13, KEY_CS4 = 5'd14;
   localparam logic [NOTE_W-1:0] KEY_DS4 = 5'd15, KEY_FS4 = 5'd16, KEY_GS4 = 5'd17;
   localparam logic [NOTE_W-1:0] KEY_AS4 = 5'd18, KEY_CS5 = 5'd19, KEY_DS5 = 5'd20;
   localparam logic [NOTE_W-1:0] KEY_FS5 = 5'd21, KEY_GS5 = 5'd22, KEY_AS5 = 5'd23;

   function automatic logic [REC_W-1:0] pack_record(input logic [NOTE_W-1:0] note,
                                                    input logic [TIME_W-1:0] t_start,
                                                    input logic [TIME_W-1:0] t_end);
      logic [REC_W-1:0] r;
      r                        = '0;
      r[NOTE_LSB  +: NOTE_W]   = note;
      r[START_LSB +: TIME_W]   = t_start;
      r[END_LSB   +: TIME_W]   = t_end;
      return r;
   endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for the raw key levels plus per-key rise/fall pulse generation.
module key_edge_sync
   import piano_pkg::*;
#(
   parameter int unsigned WIDTH = NUM_KEYS
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [WIDTH-1:0] key_in,
   output logic [WIDTH-1:0] key_rise,
   output logic [WIDTH-1:0] key_fall
);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

   // Synchronizer chain and previous-value register
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
      end else begin
         sync1_q <= key_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // One-cycle pulses on synchronized level changes
   always_comb begin
      key_rise = sync2_q & ~prev_q;
      key_fall = ~sync2_q & prev_q;
   end

endmodule

// File: rtl/note_event_recorder.sv
// Timestamps key presses/releases during a recording session and emits one packed
// record per completed note over a valid/ready handshake.
module note_event_recorder
   import piano_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                record_en,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [REC_W-1:0]    rec_data,
   output logic                recording,
   output logic [TIME_W-1:0]   tick_now,
   output logic                dropped
);

   localparam int unsigned       PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [TIME_W-1:0]  TICK_SAT  = '1;

   rec_state_e          state_q, state_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [TIME_W-1:0]   tick_q, tick_d;
   logic [NUM_KEYS-1:0] held_q, held_d, pending_q, pending_d;
   logic [TIME_W-1:0]   start_q [NUM_KEYS];
   logic [TIME_W-1:0]   start_d [NUM_KEYS];
   logic [TIME_W-1:0]   end_q   [NUM_KEYS];
   logic [TIME_W-1:0]   end_d   [NUM_KEYS];
   logic                rec_valid_q, rec_valid_d;
   logic [REC_W-1:0]    rec_data_q, rec_data_d;
   logic                dropped_q, dropped_d;
   logic [NUM_KEYS-1:0] key_rise, key_fall;
   logic [NOTE_W-1:0]   sel;

   key_edge_sync #(
      .WIDTH (NUM_KEYS)
   ) u_key_edge_sync (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_in   (key_in),
      .key_rise (key_rise),
      .key_fall (key_fall)
   );

   // Lowest-index pending key wins the output stage
   always_comb begin
      sel = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (pending_q[k]) sel = NOTE_W'(k);
      end
   end

   // Next-state: FSM, timebase, key bookkeeping and output stage
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      tick_d      = tick_q;
      held_d      = held_q;
      pending_d   = pending_q;
      start_d     = start_q;
      end_d       = end_q;
      rec_valid_d = rec_valid_q;
      rec_data_d  = rec_data_q;
      dropped_d   = dropped_q;

      unique case (state_q)
         IDLE: begin
            if (record_en) begin
               state_d   = REC;
               presc_d   = '0;
               tick_d    = '0;
               held_d    = '0;
               pending_d = '0;
               dropped_d = 1'b0;
            end
         end
         REC: begin
            if (presc_q == PRESC_MAX) begin
               presc_d = '0;
               if (tick_q != TICK_SAT) tick_d = tick_q + 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
            for (int k = 0; k < NUM_KEYS; k++) begin
               if (key_rise[k]) begin
                  if (pending_q[k]) begin
                     dropped_d = 1'b1;
                  end else if (!held_q[k]) begin
                     start_d[k] = tick_q;
                     held_d[k]  = 1'b1;
                  end
               end
               if (key_fall[k] && held_q[k]) begin
                  end_d[k]     = tick_q;
                  held_d[k]    = 1'b0;
                  pending_d[k] = 1'b1;
               end
            end
            if (!record_en) state_d = FLUSH;
         end
         FLUSH: begin
            // Held keys are closed out at the frozen timestamp; only the first cycle has any
            for (int k = 0; k < NUM_KEYS; k++) begin
               if (held_q[k]) begin
                  end_d[k]     = tick_q;
                  pending_d[k] = 1'b1;
               end
            end
            held_d = '0;
            if (pending_q == '0 && held_q == '0 && !rec_valid_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_q != IDLE) begin
         if (rec_valid_q) begin
            if (rec_ready) rec_valid_d = 1'b0;
         end else if (pending_q != '0) begin
            rec_valid_d    = 1'b1;
            rec_data_d     = pack_record(sel, start_q[sel], end_q[sel]);
            pending_d[sel] = 1'b0;
         end
      end
   end

   // State registers
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         tick_q      <= '0;
         held_q      <= '0;
         pending_q   <= '0;
         rec_valid_q <= 1'b0;
         rec_data_q  <= '0;
         dropped_q   <= 1'b0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            start_q[k] <= '0;
            end_q[k]   <= '0;
         end
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         tick_q      <= tick_d;
         held_q      <= held_d;
         pending_q   <= pending_d;
         rec_valid_q <= rec_valid_d;
         rec_data_q  <= rec_data_d;
         dropped_q   <= dropped_d;
         start_q     <= start_d;
         end_q       <= end_d;
      end
   end

   // Outputs
   always_comb begin
      rec_valid = rec_valid_q;
      rec_data  = rec_data_q;
      recording = (state_q == REC);
      tick_now  = tick_q;
      dropped   = dropped_q;
   end

endmodule
